// File: rtl/reg_xfer_seq.sv
// -----------------------------------------------------------------------------
// reg_xfer_seq
//
// Sequences one 8-bit register transfer / increment / decrement instruction
// (TAX, TAY, TXA, TYA, TSX, TXS, INX, DEX, INY, DEY) against an external
// register file. It reads the source register, writes the result to the
// destination, then does a read-modify-write of the status register P to
// update N (bit 7) and Z (bit 1). TXS skips the flag update. Illegal opcodes
// complete at once with an error and never touch the register file.
//
// Ports
//   clk_i            single clock, rising edge
//   rst_i            synchronous active-high reset
//   start_i          request to execute op_i (sampled only while idle)
//   op_i[3:0]        opcode, 0..9 legal, 10..15 illegal
//   busy_o           high whenever an operation is in flight (incl. DONE)
//   done_o           one-cycle completion pulse
//   err_o            valid with done_o, high for an illegal opcode
//   reg_addr_o[2:0]  register-file address: A=0 X=1 Y=2 S=3 P=4
//   reg_we_o         register-file write enable
//   reg_data_o[15:0] write data, always {8'h00, value}
//   reg_read_data_i  combinational read data for reg_addr_o; [15:8] ignored
// -----------------------------------------------------------------------------
module reg_xfer_seq (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [3:0]  op_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic [2:0]  reg_addr_o,
    output logic        reg_we_o,
    output logic [15:0] reg_data_o,
    input  logic [15:0] reg_read_data_i
);

    typedef enum logic [2:0] {
        REG_A = 3'd0,
        REG_X = 3'd1,
        REG_Y = 3'd2,
        REG_S = 3'd3,
        REG_P = 3'd4
    } reg_id_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD_SRC = 3'd1,
        WR_DST = 3'd2,
        RD_P   = 3'd3,
        WR_P   = 3'd4,
        DONE   = 3'd5
    } state_t;

    localparam logic [3:0] OP_TAX = 4'd0;
    localparam logic [3:0] OP_TAY = 4'd1;
    localparam logic [3:0] OP_TXA = 4'd2;
    localparam logic [3:0] OP_TYA = 4'd3;
    localparam logic [3:0] OP_TSX = 4'd4;
    localparam logic [3:0] OP_TXS = 4'd5;
    localparam logic [3:0] OP_INX = 4'd6;
    localparam logic [3:0] OP_DEX = 4'd7;
    localparam logic [3:0] OP_INY = 4'd8;
    localparam logic [3:0] OP_DEY = 4'd9;

    // Source register of each legal opcode.
    function automatic reg_id_t src_of(input logic [3:0] op);
        case (op)
            OP_TAX, OP_TAY:                 src_of = REG_A;
            OP_TXA, OP_TXS, OP_INX, OP_DEX: src_of = REG_X;
            OP_TYA, OP_INY, OP_DEY:         src_of = REG_Y;
            OP_TSX:                         src_of = REG_S;
            default:                        src_of = REG_A;
        endcase
    endfunction

    // Destination register of each legal opcode.
    function automatic reg_id_t dst_of(input logic [3:0] op);
        case (op)
            OP_TAX, OP_TSX, OP_INX, OP_DEX: dst_of = REG_X;
            OP_TAY, OP_INY, OP_DEY:         dst_of = REG_Y;
            OP_TXA, OP_TYA:                 dst_of = REG_A;
            OP_TXS:                         dst_of = REG_S;
            default:                        dst_of = REG_A;
        endcase
    endfunction

    // Transfers pass through; increments/decrements wrap modulo 256.
    function automatic logic [7:0] calc_result(input logic [3:0] op,
                                               input logic [7:0] v);
        case (op)
            OP_INX, OP_INY: calc_result = v + 8'd1;
            OP_DEX, OP_DEY: calc_result = v - 8'd1;
            default:        calc_result = v;
        endcase
    endfunction

    // Replace N (bit 7) and Z (bit 1) of P, keeping every other bit.
    function automatic logic [7:0] merge_flags(input logic [7:0] p,
                                               input logic [7:0] r);
        merge_flags = (p & 8'h7D)
                    | {r[7], 7'b000_0000}
                    | {6'b00_0000, (r == 8'h00), 1'b0};
    endfunction

    state_t     state_q;
    state_t     state_nxt;
    logic [3:0] op_q;
    logic       err_q;
    logic [7:0] res_q;
    logic [7:0] p_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            op_q    <= 4'd0;
            err_q   <= 1'b0;
            res_q   <= 8'h00;
            p_q     <= 8'h00;
        end else begin
            state_q <= state_nxt;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        op_q  <= op_i;
                        err_q <= (op_i > OP_DEY);
                    end
                end
                // Source value captured on the RD_SRC exit edge; the result is
                // formed here so WR_DST drives a registered value.
                RD_SRC: res_q <= calc_result(op_q, reg_read_data_i[7:0]);
                // P captured on the RD_P exit edge for the read-modify-write.
                RD_P:   p_q   <= reg_read_data_i[7:0];
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt  = state_q;
        busy_o     = 1'b1;
        done_o     = 1'b0;
        err_o      = 1'b0;
        reg_addr_o = REG_A;
        reg_we_o   = 1'b0;
        reg_data_o = 16'h0000;

        case (state_q)
            IDLE: begin
                busy_o = 1'b0;
                if (start_i) begin
                    state_nxt = (op_i > OP_DEY) ? DONE : RD_SRC;
                end
            end
            RD_SRC: begin
                reg_addr_o = src_of(op_q);
                state_nxt  = WR_DST;
            end
            WR_DST: begin
                reg_addr_o = dst_of(op_q);
                reg_we_o   = 1'b1;
                reg_data_o = {8'h00, res_q};
                // TXS loads the stack pointer and leaves the flags alone.
                state_nxt  = (op_q == OP_TXS) ? DONE : RD_P;
            end
            RD_P: begin
                reg_addr_o = REG_P;
                state_nxt  = WR_P;
            end
            WR_P: begin
                reg_addr_o = REG_P;
                reg_we_o   = 1'b1;
                reg_data_o = {8'h00, merge_flags(p_q, res_q)};
                state_nxt  = DONE;
            end
            DONE: begin
                done_o    = 1'b1;
                err_o     = err_q;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_reg_xfer_seq.sv
module tb_reg_xfer_seq;

    logic        clk_i;
    logic        rst_i;
    logic        start_i;
    logic [3:0]  op_i;
    logic        busy_o;
    logic        done_o;
    logic        err_o;
    logic [2:0]  reg_addr_o;
    logic        reg_we_o;
    logic [15:0] reg_data_o;
    logic [15:0] reg_read_data_i;

    reg_xfer_seq dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .start_i         (start_i),
        .op_i            (op_i),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .err_o           (err_o),
        .reg_addr_o      (reg_addr_o),
        .reg_we_o        (reg_we_o),
        .reg_data_o      (reg_data_o),
        .reg_read_data_i (reg_read_data_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Register-file model: A X Y S P
    logic [7:0] regs [5];
    logic [7:0] pre_vals [5];
    logic       pre_en;
    logic [7:0] junk;
    int         wr_cnt = 0;
    int         p_cnt  = 0;
    logic       mon_en;

    function automatic logic [7:0] rd_val(input logic [2:0] a);
        logic [7:0] v;
        v = 8'h00;
        for (int i = 0; i < 5; i++) if (a == i[2:0]) v = regs[i];
        return v;
    endfunction

    assign reg_read_data_i = {junk, rd_val(reg_addr_o)};

    always @(posedge clk_i) begin
        if (pre_en) begin
            for (int i = 0; i < 5; i++) regs[i] <= pre_vals[i];
        end else begin
            if (reg_we_o) begin
                for (int i = 0; i < 5; i++)
                    if (reg_addr_o == i[2:0]) regs[i] <= reg_data_o[7:0];
                wr_cnt <= wr_cnt + 1;
            end
            if (busy_o && reg_addr_o == 3'd4) p_cnt <= p_cnt + 1;
        end
    end

    // Idle/done address and data must be zero; upper data byte always zero.
    always @(negedge clk_i) begin
        if (mon_en) begin
            chk("data_upper", {24'h0, reg_data_o[15:8]}, 32'h0);
            if (!busy_o || done_o) begin
                chk("idle_addr", {29'h0, reg_addr_o}, 32'h0);
                chk("idle_data", {16'h0, reg_data_o}, 32'h0);
            end
        end
    end

    // Behavioural instruction table
    int src_t   [10] = '{0, 0, 1, 2, 3, 1, 1, 1, 2, 2};
    int dst_t   [10] = '{1, 2, 0, 0, 1, 3, 1, 1, 2, 2};
    int delta_t [10] = '{0, 0, 0, 0, 0, 0, 1, -1, 1, -1};

    task automatic preload(input logic [7:0] a, input logic [7:0] x, input logic [7:0] y,
                           input logic [7:0] s, input logic [7:0] p);
        @(negedge clk_i);
        pre_vals[0] = a; pre_vals[1] = x; pre_vals[2] = y; pre_vals[3] = s; pre_vals[4] = p;
        pre_en = 1'b1;
        @(negedge clk_i);
        pre_en = 1'b0;
    endtask

    task automatic run_op(input logic [3:0] op);
        logic [7:0] e [5];
        int  v, r, lat, exp_lat, exp_wr, w0, p0;
        bit  legal, got_done;
        legal = (op < 4'd10);
        for (int i = 0; i < 5; i++) e[i] = regs[i];
        exp_lat = 1;
        exp_wr  = 0;
        if (legal) begin
            v = int'(e[src_t[op]]);
            r = (v + delta_t[op] + 256) % 256;
            e[dst_t[op]] = r[7:0];
            if (op == 4'd5) begin
                exp_lat = 3; exp_wr = 1;
            end else begin
                e[4] = (e[4] & 8'h7D) | ((r >= 128) ? 8'h80 : 8'h00) | ((r == 0) ? 8'h02 : 8'h00);
                exp_lat = 5; exp_wr = 2;
            end
        end
        w0 = wr_cnt;
        p0 = p_cnt;
        @(negedge clk_i);
        start_i = 1'b1;
        op_i    = op;
        junk    = 8'($urandom);
        lat = 0;
        got_done = 0;
        while (lat < 20 && !got_done) begin
            @(negedge clk_i);
            lat++;
            if (done_o) got_done = 1;
            else begin
                chk($sformatf("busy op%0d c%0d", op, lat), {31'h0, busy_o}, 32'h1);
                start_i = 1'($urandom);
                op_i    = 4'($urandom);
                junk    = 8'($urandom);
            end
        end
        start_i = 1'b0;
        chk($sformatf("done_seen op%0d", op), {31'h0, got_done}, 32'h1);
        chk($sformatf("latency op%0d", op), lat, exp_lat);
        chk($sformatf("err op%0d", op), {31'h0, err_o}, {31'h0, !legal});
        @(negedge clk_i);
        chk($sformatf("done_pulse op%0d", op), {31'h0, done_o}, 32'h0);
        chk($sformatf("idle_busy op%0d", op), {31'h0, busy_o}, 32'h0);
        for (int i = 0; i < 5; i++)
            chk($sformatf("reg%0d op%0d", i, op), {24'h0, regs[i]}, {24'h0, e[i]});
        chk($sformatf("writes op%0d", op), wr_cnt - w0, exp_wr);
        if (!legal || op == 4'd5)
            chk($sformatf("p_access op%0d", op), p_cnt - p0, 0);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_busy"}, {31'h0, busy_o}, 32'h0);
        chk({tag, "_done"}, {31'h0, done_o}, 32'h0);
        chk({tag, "_err"},  {31'h0, err_o},  32'h0);
        chk({tag, "_we"},   {31'h0, reg_we_o}, 32'h0);
        chk({tag, "_addr"}, {29'h0, reg_addr_o}, 32'h0);
        chk({tag, "_data"}, {16'h0, reg_data_o}, 32'h0);
    endtask

    function automatic logic [7:0] rnd_val();
        logic [7:0] edge_v [4];
        edge_v[0] = 8'h00; edge_v[1] = 8'hFF; edge_v[2] = 8'h7F; edge_v[3] = 8'h80;
        if ($urandom_range(0, 2) == 0) return edge_v[$urandom_range(0, 3)];
        return 8'($urandom);
    endfunction

    initial begin
        rst_i = 1'b1; start_i = 1'b0; op_i = 4'd0; junk = 8'h00; pre_en = 1'b0; mon_en = 1'b0;
        for (int i = 0; i < 5; i++) pre_vals[i] = 8'h00;
        @(negedge clk_i);
        @(negedge clk_i);
        mon_en = 1'b1;
        chk_outputs_zero("reset");
        rst_i = 1'b0;

        // Reset wins over a simultaneous start
        @(negedge clk_i);
        rst_i = 1'b1; start_i = 1'b1; op_i = 4'd6;
        @(negedge clk_i);
        chk_outputs_zero("rst_prio");
        rst_i = 1'b0; start_i = 1'b0;

        // Directed cases
        preload(8'h11, 8'h00, 8'h22, 8'h33, 8'hFF);
        run_op(4'd6);
        chk("inx_x", {24'h0, regs[1]}, 32'h01);
        chk("inx_p", {24'h0, regs[4]}, 32'h7D);

        preload(8'h11, 8'h00, 8'h22, 8'h33, 8'h00);
        run_op(4'd7);
        chk("dex_x", {24'h0, regs[1]}, 32'hFF);
        chk("dex_p", {24'h0, regs[4]}, 32'h80);

        preload(8'h00, 8'h55, 8'h22, 8'h33, 8'h24);
        run_op(4'd0);
        chk("tax_x", {24'h0, regs[1]}, 32'h00);
        chk("tax_p", {24'h0, regs[4]}, 32'h26);

        preload(8'h11, 8'h80, 8'h22, 8'h33, 8'h5A);
        run_op(4'd5);
        chk("txs_s", {24'h0, regs[3]}, 32'h80);
        chk("txs_p", {24'h0, regs[4]}, 32'h5A);

        preload(8'h11, 8'h80, 8'h22, 8'h33, 8'h5A);
        run_op(4'hC);

        // Reset in RD_P aborts TAY; start while busy is ignored
        preload(8'h5A, 8'h01, 8'h00, 8'h33, 8'hC3);
        @(negedge clk_i);
        start_i = 1'b1; op_i = 4'd1;
        @(negedge clk_i);
        chk("abort_rdsrc_addr", {29'h0, reg_addr_o}, 32'h0);
        start_i = 1'b1; op_i = 4'd5;
        @(negedge clk_i);
        chk("abort_wrdst_addr", {29'h0, reg_addr_o}, 32'h2);
        chk("abort_wrdst_we", {31'h0, reg_we_o}, 32'h1);
        chk("abort_wrdst_data", {16'h0, reg_data_o}, 32'h5A);
        start_i = 1'b0;
        @(negedge clk_i);
        chk("abort_rdp_addr", {29'h0, reg_addr_o}, 32'h4);
        chk("abort_rdp_we", {31'h0, reg_we_o}, 32'h0);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        chk_outputs_zero("abort");
        chk("abort_y_kept", {24'h0, regs[2]}, 32'h5A);
        chk("abort_p_kept", {24'h0, regs[4]}, 32'hC3);
        chk("abort_s_kept", {24'h0, regs[3]}, 32'h33);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i);
            chk($sformatf("abort_nodone%0d", k), {31'h0, done_o}, 32'h0);
            chk($sformatf("abort_idle%0d", k), {31'h0, busy_o}, 32'h0);
        end

        // Randomized operations
        for (int n = 0; n < 60; n++) begin
            preload(rnd_val(), rnd_val(), rnd_val(), rnd_val(), 8'($urandom));
            run_op(4'($urandom_range(0, 15)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_xfer_seq.md
REG_XFER_SEQ -- requirements
Module: reg_xfer_seq

Interface
REQ-001 The block SHALL have no parameters; the register-file port data width is fixed at 16 bits, with the 8-bit register value in bits [7:0].
REQ-002 clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 rst_i  input  1  synchronous, active-high reset.
REQ-004 start_i  input  1  request to execute op_i; sampled only in IDLE.
REQ-005 op_i  input  4  operation: 0 TAX, 1 TAY, 2 TXA, 3 TYA, 4 TSX, 5 TXS, 6 INX, 7 DEX, 8 INY, 9 DEY; 10-15 illegal.
REQ-006 busy_o  output  1  high in every state except IDLE.
REQ-007 done_o  output  1  one-cycle completion pulse.
REQ-008 err_o  output  1  valid with done_o; high for an illegal op.
REQ-009 reg_addr_o  output  3 (reg_id_t)  register-file address: A=0, X=1, Y=2, S=3, P=4.
REQ-010 reg_we_o  output  1  register-file write enable.
REQ-011 reg_data_o  output  16  write data, always {8'h00, value}.
REQ-012 reg_read_data_i  input  16  combinational read data for reg_addr_o in the same cycle; bits [15:8] ignored.

Function
REQ-013 FSM states SHALL be IDLE, RD_SRC, WR_DST, RD_P, WR_P, DONE.
REQ-014 IDLE with start_i=1 SHALL latch op_i and go to RD_SRC for a legal op, or to DONE with err latched for an illegal op.
REQ-015 start_i SHALL be ignored in all states other than IDLE; op_i SHALL NOT be re-sampled mid-operation.
REQ-016 Source/destination mapping: TAX A->X, TAY A->Y, TXA X->A, TYA Y->A, TSX S->X, TXS X->S, INX/DEX X->X, INY/DEY Y->Y.
REQ-017 RD_SRC: reg_addr_o=src, reg_we_o=0; reg_read_data_i[7:0] SHALL be captured at the clock edge leaving the state.
REQ-018 Result: transfers pass the value unchanged; INx adds 1 mod 256; DEx subtracts 1 mod 256 (FF+1=00, 00-1=FF).
REQ-019 WR_DST: reg_addr_o=dst, reg_we_o=1, reg_data_o={8'h00,result}; next state RD_P, or DONE for TXS (TXS updates no flags).
REQ-020 RD_P: reg_addr_o=4, reg_we_o=0; P[7:0] SHALL be captured at the exit edge.
REQ-021 WR_P: reg_addr_o=4, reg_we_o=1, data = (P & 8'h7D) | (result[7]<<7) | ((result==0)<<1); all other P bits SHALL be preserved.
REQ-022 DONE: done_o=1 for exactly one cycle, err_o=latched err, then IDLE.
REQ-023 Latency from start-accept edge to done_o: 5 cycles for flag-updating ops, 3 cycles for TXS, 1 cycle for illegal ops.
REQ-024 reg_we_o SHALL be 1 only in WR_DST and WR_P; an illegal op SHALL produce no writes.
REQ-025 In IDLE and DONE, reg_addr_o SHALL be 0 and reg_data_o SHALL be 16'h0000.

Reset
REQ-026 rst_i=1 at a clock edge SHALL force IDLE and set busy_o=0, done_o=0, err_o=0, reg_we_o=0, reg_addr_o=0, reg_data_o=0, and clear the latched op/result/err.
REQ-027 Reset mid-operation SHALL abort the operation with no done_o pulse; writes already committed are not undone.
REQ-028 rst_i SHALL take priority over start_i in the same cycle.

Verification
REQ-029 X=8'h00, INX -> WR_DST writes X=16'h0001; with P=8'hFF, WR_P writes P=8'h7D; done_o 5 cycles after start, err_o=0.
REQ-030 X=8'h00, DEX, P=8'h00 -> X=16'h00FF, P=8'h80.
REQ-031 A=8'h00, TAX, P=8'h24 -> X=16'h0000, P=8'h26.
REQ-032 X=8'h80, TXS -> S=16'h0080, no P access, done_o 3 cycles after start.
REQ-033 op_i=4'hC -> done_o and err_o high 1 cycle after start, reg_we_o never asserted.
REQ-034 TAY started, rst_i asserted in RD_P -> next cycle IDLE with all outputs 0 and no done_o pulse; start_i pulsed while busy is ignored.
